// File: rtl/load_align_unit.sv
// ============================================================================
// load_align_unit
// ----------------------------------------------------------------------------
// Read side of the MIPS data-memory interface. A load request from the MEM
// stage is checked for alignment, turned into a word read over a req/ready
// handshake, and the returned word is narrowed to the addressed byte or
// halfword with sign or zero extension. The result is presented with a
// one-cycle ld_valid pulse; busy lets the pipeline stall meanwhile.
//
// Parameters:
//   TIMEOUT   cycles mem_req may wait for mem_ready before the load aborts
//             with an error (1..255)
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   ld_req     in   1   load request, sampled only while busy=0
//   ld_type    in   3   000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others reserved
//   ld_addr    in  32   byte address of the load
//   busy       out  1   a load is outstanding
//   ld_valid   out  1   one-cycle pulse, ld_data/ld_err are valid
//   ld_data    out 32   aligned, extended load result
//   ld_err     out  1   misaligned, reserved type or timeout
//   mem_req    out  1   read request to data memory
//   mem_addr   out 30   word address, stable while mem_req=1
//   mem_rdata  in  32   read word, valid with mem_ready
//   mem_ready  in   1   read completion, only looked at while mem_req=1
// ============================================================================
module load_align_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req,
    input  logic [2:0]  ld_type,
    input  logic [31:0] ld_addr,
    output logic        busy,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        ld_err,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [2:0] T_LW  = 3'b000;
    localparam logic [2:0] T_LH  = 3'b001;
    localparam logic [2:0] T_LHU = 3'b010;
    localparam logic [2:0] T_LB  = 3'b011;
    localparam logic [2:0] T_LBU = 3'b100;

    // The timeout fires on the wait cycle where the counter already holds
    // TIMEOUT-1, so mem_req is high for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  type_q;
    logic [1:0]  lane_q;
    logic [7:0]  wait_cnt;
    logic        req_legal;
    logic        finish_ok;
    logic        finish_err;
    logic [15:0] sel_half;
    logic [7:0]  sel_byte;
    logic [31:0] extracted;

    // Outputs that are pure functions of the state. Keeping mem_req and
    // ld_valid combinational from the state register means an async reset
    // drops them in the same cycle it is asserted.
    assign busy     = (state != IDLE);
    assign mem_req  = (state == WAIT);
    assign ld_valid = (state == RESP);

    // Decide whether an incoming request is legal: words must be word
    // aligned, halfwords halfword aligned, bytes are always fine and the
    // reserved encodings are rejected outright.
    always_comb begin
        req_legal = 1'b0;
        case (ld_type)
            T_LW:         req_legal = (ld_addr[1:0] == 2'b00);
            T_LH, T_LHU:  req_legal = ~ld_addr[0];
            T_LB, T_LBU:  req_legal = 1'b1;
            default:      req_legal = 1'b0;
        endcase
    end

    // Narrow the returned word using the type and byte lane captured when
    // the request was accepted, then sign or zero extend it.
    always_comb begin
        sel_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        sel_byte  = mem_rdata[7:0];
        extracted = '0;
        case (lane_q)
            2'b00:   sel_byte = mem_rdata[7:0];
            2'b01:   sel_byte = mem_rdata[15:8];
            2'b10:   sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        case (type_q)
            T_LW:    extracted = mem_rdata;
            T_LH:    extracted = {{16{sel_half[15]}}, sel_half};
            T_LHU:   extracted = {16'h0000, sel_half};
            T_LB:    extracted = {{24{sel_byte[7]}}, sel_byte};
            T_LBU:   extracted = {24'h000000, sel_byte};
            default: extracted = '0;
        endcase
    end

    // Next-state logic. finish_ok/finish_err mark the transition into RESP
    // and tell the result registers what to capture. A mem_ready arriving
    // on the same cycle as the timeout still counts as a good completion.
    always_comb begin
        state_next = state;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state)
            IDLE: begin
                if (ld_req) begin
                    if (req_legal) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                        finish_err = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_next = RESP;
                    finish_ok  = 1'b1;
                end else if (wait_cnt == CNT_LAST) begin
                    state_next = RESP;
                    finish_err = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture: type, byte lane and word address are only taken
    // while idle, so requests arriving during a load are simply dropped and
    // mem_addr stays stable for the whole handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q   <= '0;
            lane_q   <= '0;
            mem_addr <= '0;
        end else if (state == IDLE && ld_req) begin
            type_q   <= ld_type;
            lane_q   <= ld_addr[1:0];
            mem_addr <= ld_addr[31:2];
        end
    end

    // Timeout counter: counts wait cycles without mem_ready and is cleared
    // whenever the FSM is not actively waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Result registers are loaded only on the way into RESP and otherwise
    // keep their previous contents, so the last result stays readable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_data <= '0;
            ld_err  <= 1'b0;
        end else if (finish_ok) begin
            ld_data <= extracted;
            ld_err  <= 1'b0;
        end else if (finish_err) begin
            ld_data <= '0;
            ld_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// ============================================================================
// tb_load_align_unit
// ----------------------------------------------------------------------------
// Directed testbench for load_align_unit with TIMEOUT=4. Each vector carries
// hand-computed expected values for data, error flag and request length.
// ============================================================================
module tb_load_align_unit;

    logic        clk;
    logic        rst;
    logic        ld_req;
    logic [2:0]  ld_type;
    logic [31:0] ld_addr;
    logic        busy;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_err;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int assertCount = 0;
    int failCount   = 0;

    load_align_unit #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_type   (ld_type),
        .ld_addr   (ld_addr),
        .busy      (busy),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_err    (ld_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one load from IDLE and play memory. readyDelay is the number of
    // request cycles before mem_ready (0 = same cycle mem_req rises), or -1
    // for a memory that never answers. expReqCycles is how long mem_req is
    // expected to stay high (0 for a request rejected up front).
    task automatic applyStimulus(input string tag, input logic [2:0] ty,
                                 input logic [31:0] addr, input logic [31:0] rdata,
                                 input int readyDelay, input int expReqCycles,
                                 input logic [31:0] expData, input logic expErr);
        int n;
        int reqCycles;
        logic addrBad;
        n         = 0;
        reqCycles = 0;
        addrBad   = 1'b0;
        ld_req    = 1'b1;
        ld_type   = ty;
        ld_addr   = addr;
        mem_rdata = rdata;
        mem_ready = 1'b0;
        nextCycle();
        ld_req = 1'b0;
        checkOutput({tag, "_busy1"}, 32'(busy), 32'd1);
        while (!ld_valid && n < 20) begin
            if (mem_req) begin
                reqCycles++;
                if (mem_addr !== addr[31:2]) addrBad = 1'b1;
            end
            mem_ready = (n == readyDelay);
            nextCycle();
            mem_ready = 1'b0;
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(ld_valid), 32'd1);
        checkOutput({tag, "_reqCycles"}, 32'(reqCycles), 32'(expReqCycles));
        checkOutput({tag, "_addrStable"}, 32'(addrBad), 32'd0);
        checkOutput({tag, "_data"}, ld_data, expData);
        checkOutput({tag, "_err"}, 32'(ld_err), 32'(expErr));
        checkOutput({tag, "_busyResp"}, 32'(busy), 32'd1);
        nextCycle();
        checkOutput({tag, "_validPulse"}, 32'(ld_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_dataHold"}, ld_data, expData);
    endtask

    initial begin
        int n;
        logic addrBad;
        $display("[TB] load_align_unit directed test start");
        rst       = 1'b1;
        ld_req    = 1'b0;
        ld_type   = 3'b000;
        ld_addr   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #3;
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_valid",    32'(ld_valid), 32'd0);
        checkOutput("rst_err",      32'(ld_err),   32'd0);
        checkOutput("rst_memReq",   32'(mem_req),  32'd0);
        checkOutput("rst_data",     ld_data,       32'd0);
        checkOutput("rst_memAddr",  32'(mem_addr), 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;

        // mem_ready with no request outstanding must not wake the FSM.
        mem_ready = 1'b1;
        nextCycle();
        mem_ready = 1'b0;
        checkOutput("strayReady_busy",  32'(busy),     32'd0);
        checkOutput("strayReady_valid", 32'(ld_valid), 32'd0);

        // Legal loads with hand-computed extraction results.
        applyStimulus("lb3",   3'b011, 32'h1000_0003, 32'h80FF_1234, 0, 1, 32'hFFFF_FF80, 1'b0);
        applyStimulus("lhu2",  3'b010, 32'h2000_0002, 32'h8001_7FFF, 1, 2, 32'h0000_8001, 1'b0);
        applyStimulus("lh0",   3'b001, 32'h2000_0000, 32'h8001_7FFF, 0, 1, 32'h0000_7FFF, 1'b0);
        applyStimulus("lbu1",  3'b100, 32'h3000_0005, 32'h80FF_1234, 0, 1, 32'h0000_0012, 1'b0);
        applyStimulus("lh2",   3'b001, 32'h3000_0006, 32'h80FF_1234, 2, 3, 32'hFFFF_80FF, 1'b0);
        applyStimulus("lb2",   3'b011, 32'h3000_000A, 32'h80FF_1234, 0, 1, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("lbu3",  3'b100, 32'h3000_000B, 32'h80FF_1234, 0, 1, 32'h0000_0080, 1'b0);
        applyStimulus("lw",    3'b000, 32'h0000_0010, 32'hDEAD_BEEF, 2, 3, 32'hDEAD_BEEF, 1'b0);

        // Rejected requests: no memory access, error response one cycle later.
        applyStimulus("lwMis", 3'b000, 32'h0000_0011, 32'hAAAA_AAAA, 0, 0, 32'h0000_0000, 1'b1);
        applyStimulus("lhMis", 3'b001, 32'h0000_0013, 32'hAAAA_AAAA, 0, 0, 32'h0000_0000, 1'b1);
        applyStimulus("lhuMis",3'b010, 32'h0000_0015, 32'hAAAA_AAAA, 0, 0, 32'h0000_0000, 1'b1);
        applyStimulus("rsvd",  3'b110, 32'h0000_0020, 32'hAAAA_AAAA, 0, 0, 32'h0000_0000, 1'b1);

        // Timeout boundary: silent memory versus ready on the last cycle.
        applyStimulus("tmo",   3'b000, 32'h0000_0040, 32'h5555_5555, -1, 4, 32'h0000_0000, 1'b1);
        applyStimulus("tmoRdy",3'b000, 32'h0000_0044, 32'h1234_5678, 3, 4, 32'h1234_5678, 1'b0);

        // Requests held every cycle while busy: only the first is served and
        // the next one is taken in the idle cycle after the response.
        ld_req    = 1'b1;
        ld_type   = 3'b000;
        ld_addr   = 32'h0000_0080;
        mem_rdata = 32'hCAFE_F00D;
        nextCycle();
        ld_addr = 32'h0000_0084;
        n       = 0;
        addrBad = 1'b0;
        while (!ld_valid && n < 20) begin
            if (mem_addr !== 30'h20) addrBad = 1'b1;
            mem_ready = (n == 3);
            nextCycle();
            mem_ready = 1'b0;
            n++;
        end
        checkOutput("held_valid",     32'(ld_valid), 32'd1);
        checkOutput("held_addrFirst", 32'(addrBad),  32'd0);
        checkOutput("held_data",      ld_data,       32'hCAFE_F00D);
        checkOutput("held_busyResp",  32'(busy),     32'd1);
        nextCycle();
        checkOutput("held_idleGap",   32'(busy),     32'd0);
        nextCycle();
        ld_req    = 1'b0;
        checkOutput("held_secondReq",  32'(mem_req),  32'd1);
        checkOutput("held_secondAddr", 32'(mem_addr), 32'h21);
        mem_rdata = 32'h0BAD_CAFE;
        mem_ready = 1'b1;
        nextCycle();
        mem_ready = 1'b0;
        checkOutput("held_secondValid", 32'(ld_valid), 32'd1);
        checkOutput("held_secondData",  ld_data,       32'h0BAD_CAFE);
        nextCycle();
        checkOutput("held_secondIdle",  32'(busy),     32'd0);

        // Asynchronous reset while waiting on memory.
        ld_req    = 1'b1;
        ld_type   = 3'b000;
        ld_addr   = 32'h0000_0100;
        mem_rdata = 32'h7777_7777;
        nextCycle();
        ld_req = 1'b0;
        checkOutput("arst_inWait", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_memReq", 32'(mem_req),  32'd0);
        checkOutput("arst_busy",   32'(busy),     32'd0);
        checkOutput("arst_valid",  32'(ld_valid), 32'd0);
        nextCycle();
        rst       = 1'b0;
        mem_ready = 1'b1;
        nextCycle();
        mem_ready = 1'b0;
        checkOutput("arst_noValid", 32'(ld_valid), 32'd0);
        checkOutput("arst_idle",    32'(busy),     32'd0);
        checkOutput("arst_data",    ld_data,       32'd0);
        applyStimulus("postRst", 3'b000, 32'h0000_0200, 32'h0102_0304, 1, 2, 32'h0102_0304, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
